// File: rtl/wine_conveyor_ctrl.sv
// Wine bottling conveyor sequencer.
// Synchronises the start/stop buttons, the bottle sensor and the cork refill
// button, then steps each bottle through move -> fill -> cap. It also counts
// bottles per box and tracks cork stock.
// Optional jam watchdog on the MOVE state: define CONVEYOR_WATCHDOG_EN.
module wine_conveyor_ctrl #(
  parameter int FILL_TICKS   = 8,
  parameter int CAP_TICKS    = 3,
  parameter int BOX_SIZE     = 6,
  parameter int CORK_MAX     = 20,
  parameter int MOVE_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk_en,
  input  logic       start_pb,
  input  logic       stop_pb,
  input  logic       bottle_sensor,
  input  logic       cork_refill,
  output logic       motor_on,
  output logic       valve_open,
  output logic       capper_on,
  output logic       box_done,
  output logic [3:0] bottle_count,
  output logic [4:0] cork_count,
  output logic       alarm_empty,
  output logic       alarm_jam,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MOVE     = 3'd1,
    FILL     = 3'd2,
    CAP      = 3'd3,
    BOX_FULL = 3'd4,
    ALARM    = 3'd5
  } state_t;

  // The tick counter must be able to reach the longest interval of any state
  localparam int TMAX_FC = (FILL_TICKS > CAP_TICKS) ? FILL_TICKS : CAP_TICKS;
  localparam int TMAX    = (TMAX_FC > MOVE_TIMEOUT) ? TMAX_FC : MOVE_TIMEOUT;
  localparam int TW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TICKS - 1);
  localparam logic [TW-1:0] CAP_LAST  = TW'(CAP_TICKS - 1);
  localparam logic [3:0]    BOX_LAST  = 4'(BOX_SIZE - 1);
  localparam logic [4:0]    CORK_FULL = 5'(CORK_MAX);

  state_t        cur_state, state_next;
  logic [TW-1:0] tick_cnt;
  logic          stop_req;

  // Input bit order: {cork_refill, bottle_sensor, stop_pb, start_pb}
  logic [3:0] raw_in, sync1, sync2, prev, ev;
  logic       start_ev, stop_ev, bottle_ev, refill_ev;

  logic fill_done, cap_done, stop_eff;
  logic cap_exit, empty_set, jam_set, alarm_clear;

  assign raw_in    = {cork_refill, bottle_sensor, stop_pb, start_pb};
  assign start_ev  = ev[0];
  assign stop_ev   = ev[1];
  assign bottle_ev = ev[2];
  assign refill_ev = ev[3];

  // Two-flop synchroniser, then a registered rising-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ev    <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      prev  <= sync2;
      ev    <= sync2 & ~prev;
    end
  end

  // Slow-tick counter; restarts at every state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (state_next != cur_state) begin
      tick_cnt <= '0;
    end else if (slow_clk_en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign fill_done = slow_clk_en && (tick_cnt == FILL_LAST);
  assign cap_done  = slow_clk_en && (tick_cnt == CAP_LAST);
  // A stop that arrives in the exit clock itself still counts as a request
  assign stop_eff  = stop_req | stop_ev;

`ifdef CONVEYOR_WATCHDOG_EN
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TIMEOUT - 1);
  logic move_timeout;
  assign move_timeout = slow_clk_en && (tick_cnt == MOVE_LAST);
`endif

  // Next-state decode plus the side effects that depend on the transition
  always_comb begin
    state_next  = cur_state;
    cap_exit    = 1'b0;
    empty_set   = 1'b0;
    jam_set     = 1'b0;
    alarm_clear = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start_ev && !stop_ev) begin
          if (cork_count != 5'd0) begin
            state_next = MOVE;
          end else begin
            state_next = ALARM;
            empty_set  = 1'b1;
          end
        end
      end
      MOVE: begin
        if (stop_ev) begin
          state_next = IDLE;
        end else if (bottle_ev) begin
          state_next = FILL;
        end
`ifdef CONVEYOR_WATCHDOG_EN
        else if (move_timeout) begin
          state_next = ALARM;
          jam_set    = 1'b1;
        end
`endif
      end
      FILL: begin
        if (fill_done) state_next = CAP;
      end
      CAP: begin
        if (cap_done) begin
          cap_exit = 1'b1;
          if (bottle_count == BOX_LAST) begin
            state_next = BOX_FULL;
          end else if (cork_count <= 5'd1) begin
            state_next = ALARM;
            empty_set  = 1'b1;
          end else if (stop_eff) begin
            state_next = IDLE;
          end else begin
            state_next = MOVE;
          end
        end
      end
      BOX_FULL: begin
        if (cork_count == 5'd0) begin
          state_next = ALARM;
          empty_set  = 1'b1;
        end else if (stop_eff) begin
          state_next = IDLE;
        end else begin
          state_next = MOVE;
        end
      end
      ALARM: begin
        if (refill_ev) begin
          state_next  = IDLE;
          alarm_clear = 1'b1;
        end
`ifdef CONVEYOR_WATCHDOG_EN
        else if (alarm_jam && start_ev) begin
          state_next  = IDLE;
          alarm_clear = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and Moore outputs, decoded from the next state so that
  // outputs change in the same clock as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= IDLE;
      motor_on    <= 1'b0;
      valve_open  <= 1'b0;
      capper_on   <= 1'b0;
      box_done    <= 1'b0;
      alarm_empty <= 1'b0;
    end else begin
      cur_state   <= state_next;
      motor_on    <= (state_next == MOVE);
      valve_open  <= (state_next == FILL);
      capper_on   <= (state_next == CAP);
      box_done    <= (state_next == BOX_FULL);
      alarm_empty <= empty_set | (alarm_empty & ~alarm_clear & (state_next == ALARM));
    end
  end

`ifdef CONVEYOR_WATCHDOG_EN
  // Jam alarm holds until a refill or start releases the ALARM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_jam <= 1'b0;
    end else begin
      alarm_jam <= jam_set | (alarm_jam & ~alarm_clear & (state_next == ALARM));
    end
  end
`else
  assign alarm_jam = 1'b0;
`endif

  // Pending stop: lets the current bottle finish before halting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_req <= 1'b0;
    end else if (state_next == IDLE) begin
      stop_req <= 1'b0;
    end else if (stop_ev && (cur_state == FILL || cur_state == CAP ||
                             cur_state == BOX_FULL)) begin
      stop_req <= 1'b1;
    end
  end

  // Bottle-per-box counter; holds BOX_SIZE for the single BOX_FULL clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bottle_count <= '0;
    end else if (cap_exit) begin
      bottle_count <= bottle_count + 4'd1;
    end else if (cur_state == BOX_FULL) begin
      bottle_count <= '0;
    end
  end

  // Cork stock: a refill takes priority over a simultaneous consumption
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cork_count <= CORK_FULL;
    end else if (refill_ev) begin
      cork_count <= CORK_FULL;
    end else if (cap_exit && cork_count != 5'd0) begin
      cork_count <= cork_count - 5'd1;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_wine_conveyor_ctrl.sv
// Directed bench for wine_conveyor_ctrl. dut runs default parameters; dut2
// uses a short cork stock and short timings for the alarm paths.
module tb_wine_conveyor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slow_clk_en;
  logic       start_pb, stop_pb, bottle_sensor, cork_refill;
  logic       motor_on, valve_open, capper_on, box_done, alarm_empty, alarm_jam;
  logic [3:0] bottle_count;
  logic [4:0] cork_count;
  logic [2:0] state;

  logic       start2, stop2, bottle2, refill2;
  logic       motor2, valve2, capper2, box2, empty2, jam2;
  logic [3:0] bcount2;
  logic [4:0] cork2;
  logic [2:0] state2;

  int n_checks = 0;
  int n_fail   = 0;
  int tcnt     = 0;

  always #5 clk = ~clk;

  // One-clock slow tick every fourth clock, changed on the falling edge
  always @(negedge clk) begin
    tcnt        = tcnt + 1;
    slow_clk_en = (tcnt % 4 == 0);
  end

  wine_conveyor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_en(slow_clk_en),
    .start_pb(start_pb), .stop_pb(stop_pb), .bottle_sensor(bottle_sensor),
    .cork_refill(cork_refill), .motor_on(motor_on), .valve_open(valve_open),
    .capper_on(capper_on), .box_done(box_done), .bottle_count(bottle_count),
    .cork_count(cork_count), .alarm_empty(alarm_empty), .alarm_jam(alarm_jam),
    .state(state)
  );

  wine_conveyor_ctrl #(
    .FILL_TICKS(2), .CAP_TICKS(1), .BOX_SIZE(6), .CORK_MAX(2), .MOVE_TIMEOUT(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .slow_clk_en(slow_clk_en),
    .start_pb(start2), .stop_pb(stop2), .bottle_sensor(bottle2),
    .cork_refill(refill2), .motor_on(motor2), .valve_open(valve2),
    .capper_on(capper2), .box_done(box2), .bottle_count(bcount2),
    .cork_count(cork2), .alarm_empty(empty2), .alarm_jam(jam2),
    .state(state2)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: start_pb      = v;
      1: stop_pb       = v;
      2: bottle_sensor = v;
      3: cork_refill   = v;
      4: start2        = v;
      5: bottle2       = v;
      6: refill2       = v;
      default: stop2   = v;
    endcase
  endtask

  task automatic pulse(input int which, input int n);
    drive(which, 1'b1);
    repeat (n) step();
    drive(which, 1'b0);
  endtask

  task automatic wait_st(input bit sel, input logic [2:0] s, input int budget,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if ((sel ? state2 : state) == s) ok = 1'b1;
    end
  endtask

  // One bottle on dut from MOVE; optionally presses stop once FILL is seen
  task automatic run_bottle(input bit do_stop, output bit ok, output int box_pulses,
                            output int vticks, output int cticks, output int vclk,
                            output bit saw_cap, output bit overlap);
    bit left, stopped;
    int stop_cnt;
    ok = 1'b0; box_pulses = 0; vticks = 0; cticks = 0; vclk = 0;
    saw_cap = 1'b0; overlap = 1'b0; left = 1'b0; stopped = 1'b0; stop_cnt = 0;
    bottle_sensor = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (i == 1) bottle_sensor = 1'b0;
      if (stop_cnt > 0) begin
        stop_cnt--;
        if (stop_cnt == 0) stop_pb = 1'b0;
      end
      if (valve_open) begin
        vclk++;
        if (slow_clk_en) vticks++;
      end
      if (capper_on) begin
        saw_cap = 1'b1;
        if (slow_clk_en) cticks++;
      end
      if (box_done) box_pulses++;
      if ((valve_open && capper_on) || (motor_on && valve_open)) overlap = 1'b1;
      if (state != 3'd1) left = 1'b1;
      if (do_stop && !stopped && state == 3'd2) begin
        stop_pb = 1'b1; stopped = 1'b1; stop_cnt = 2;
      end
      if (left && (state == 3'd1 || state == 3'd0 || state == 3'd5)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if ({motor_on, valve_open, capper_on, box_done, alarm_empty, alarm_jam} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {motor_on, valve_open, capper_on, box_done, alarm_empty, alarm_jam});
    end
    n_checks++;
    if (bottle_count !== 4'd0 || cork_count !== 5'd20) begin
      n_fail++;
      $display("FAIL reset_counts: got bottle=%0d cork=%0d expected 0/20",
               bottle_count, cork_count);
    end
    n_checks++;
    if (cork2 !== 5'd2) begin
      n_fail++; $display("FAIL reset_cork2: got %0d expected 2", cork2);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    int k;
    k = 0;
    start_pb = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) start_pb = 1'b0;
      if (state == 3'd1 && k == 0) k = i;
    end
    n_checks++;
    if (!(k == 3 || k == 4)) begin
      n_fail++; $display("FAIL start_latency: got %0d clk expected 3 or 4", k);
    end
    n_checks++;
    if (state !== 3'd1 || motor_on !== 1'b1) begin
      n_fail++; $display("FAIL start_move: got state=%0d motor=%0d expected 1/1",
                         state, motor_on);
    end
    n_checks++;
    if (cork_count !== 5'd20 || bottle_count !== 4'd0) begin
      n_fail++; $display("FAIL start_counts: got cork=%0d bottle=%0d expected 20/0",
                         cork_count, bottle_count);
    end
  endtask

  task automatic test_fill_cap();
    bit ok, sc, ov;
    int bp, vt, ct, vc;
    run_bottle(1'b0, ok, bp, vt, ct, vc, sc, ov);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fill_timeout: got state=%0d expected return to 1", state);
    end
    n_checks++;
    if (vt !== 8 || ct !== 3) begin
      n_fail++; $display("FAIL fill_cap_ticks: got valve=%0d capper=%0d expected 8/3", vt, ct);
    end
    n_checks++;
    if (!(vc >= 29 && vc <= 32)) begin
      n_fail++; $display("FAIL fill_clks: got %0d expected 29..32", vc);
    end
    n_checks++;
    if (ov) begin
      n_fail++; $display("FAIL actuator_overlap: got 1 expected 0");
    end
    n_checks++;
    if (bottle_count !== 4'd1 || cork_count !== 5'd19 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL first_bottle: got bottle=%0d cork=%0d state=%0d expected 1/19/1",
               bottle_count, cork_count, state);
    end
  endtask

  task automatic test_box();
    bit ok, sc, ov, all_ok;
    int bp, vt, ct, vc, early;
    all_ok = 1'b1; early = 0;
    for (int b = 2; b <= 5; b++) begin
      run_bottle(1'b0, ok, bp, vt, ct, vc, sc, ov);
      all_ok &= ok;
      early += bp;
    end
    n_checks++;
    if (bottle_count !== 4'd5 || early !== 0) begin
      n_fail++; $display("FAIL box_partial: got bottle=%0d pulses=%0d expected 5/0",
                         bottle_count, early);
    end
    run_bottle(1'b0, ok, bp, vt, ct, vc, sc, ov);
    all_ok &= ok;
    n_checks++;
    if (!all_ok) begin
      n_fail++; $display("FAIL box_run: got stalled run expected all bottles complete");
    end
    n_checks++;
    if (bp !== 1) begin
      n_fail++; $display("FAIL box_done_pulse: got %0d clk expected 1", bp);
    end
    n_checks++;
    if (bottle_count !== 4'd0 || state !== 3'd1 || cork_count !== 5'd14) begin
      n_fail++;
      $display("FAIL box_after: got bottle=%0d state=%0d cork=%0d expected 0/1/14",
               bottle_count, state, cork_count);
    end
  endtask

  task automatic test_stop_in_fill();
    bit ok, sc, ov;
    int bp, vt, ct, vc;
    run_bottle(1'b1, ok, bp, vt, ct, vc, sc, ov);
    n_checks++;
    if (!ok || !sc || vt !== 8) begin
      n_fail++; $display("FAIL stop_completes: got ok=%0d cap=%0d vticks=%0d expected 1/1/8",
                         ok, sc, vt);
    end
    n_checks++;
    if (state !== 3'd0 || motor_on !== 1'b0) begin
      n_fail++; $display("FAIL stop_idle: got state=%0d motor=%0d expected 0/0", state, motor_on);
    end
    n_checks++;
    if (bottle_count !== 4'd1 || cork_count !== 5'd13) begin
      n_fail++; $display("FAIL stop_counts: got bottle=%0d cork=%0d expected 1/13",
                         bottle_count, cork_count);
    end
  endtask

  task automatic test_idle_cases();
    start_pb = 1'b1; stop_pb = 1'b1;
    repeat (3) step();
    start_pb = 1'b0; stop_pb = 1'b0;
    repeat (8) step();
    n_checks++;
    if (state !== 3'd0 || motor_on !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_idle: got state=%0d motor=%0d expected 0/0",
                         state, motor_on);
    end
    pulse(3, 2);
    repeat (8) step();
    n_checks++;
    if (cork_count !== 5'd20 || state !== 3'd0) begin
      n_fail++; $display("FAIL refill_idle: got cork=%0d state=%0d expected 20/0",
                         cork_count, state);
    end
  endtask

  task automatic test_empty();
    bit ok, all_ok;
    all_ok = 1'b1;
    pulse(4, 2);
    wait_st(1'b1, 3'd1, 20, ok);  all_ok &= ok;
    pulse(5, 2);
    wait_st(1'b1, 3'd2, 20, ok);  all_ok &= ok;
    wait_st(1'b1, 3'd1, 100, ok); all_ok &= ok;
    n_checks++;
    if (cork2 !== 5'd1 || bcount2 !== 4'd1) begin
      n_fail++; $display("FAIL empty_first: got cork=%0d bottle=%0d expected 1/1", cork2, bcount2);
    end
    pulse(5, 2);
    wait_st(1'b1, 3'd2, 20, ok);  all_ok &= ok;
    wait_st(1'b1, 3'd5, 100, ok); all_ok &= ok;
    n_checks++;
    if (!all_ok) begin
      n_fail++; $display("FAIL empty_run: got state=%0d expected to reach 5", state2);
    end
    n_checks++;
    if (empty2 !== 1'b1 || motor2 !== 1'b0 || jam2 !== 1'b0 || cork2 !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_alarm: got empty=%0d motor=%0d jam=%0d cork=%0d expected 1/0/0/0",
               empty2, motor2, jam2, cork2);
    end
    pulse(4, 2);
    repeat (8) step();
    n_checks++;
    if (state2 !== 3'd5) begin
      n_fail++; $display("FAIL empty_start_ignored: got state=%0d expected 5", state2);
    end
    pulse(6, 2);
    wait_st(1'b1, 3'd0, 20, ok);
    n_checks++;
    if (!ok || cork2 !== 5'd2 || empty2 !== 1'b0) begin
      n_fail++; $display("FAIL empty_refill: got state=%0d cork=%0d empty=%0d expected 0/2/0",
                         state2, cork2, empty2);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    pulse(4, 2);
    wait_st(1'b1, 3'd1, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL wd_enter_move: got state=%0d expected 1", state2);
    end
`ifdef CONVEYOR_WATCHDOG_EN
    wait_st(1'b1, 3'd5, 40, ok);
    n_checks++;
    if (!ok || jam2 !== 1'b1 || empty2 !== 1'b0 || motor2 !== 1'b0) begin
      n_fail++; $display("FAIL wd_trip: got state=%0d jam=%0d empty=%0d motor=%0d expected 5/1/0/0",
                         state2, jam2, empty2, motor2);
    end
    pulse(4, 2);
    wait_st(1'b1, 3'd0, 20, ok);
    n_checks++;
    if (!ok || jam2 !== 1'b0 || cork2 !== 5'd2) begin
      n_fail++; $display("FAIL wd_release: got state=%0d jam=%0d cork=%0d expected 0/0/2",
                         state2, jam2, cork2);
    end
`else
    repeat (80) step();
    n_checks++;
    if (state2 !== 3'd1 || jam2 !== 1'b0 || motor2 !== 1'b1) begin
      n_fail++; $display("FAIL no_watchdog: got state=%0d jam=%0d motor=%0d expected 1/0/1",
                         state2, jam2, motor2);
    end
`endif
  endtask

  task automatic test_async_reset();
    bit ok, all_ok;
    all_ok = 1'b1;
    pulse(0, 2);
    wait_st(1'b0, 3'd1, 20, ok); all_ok &= ok;
    pulse(2, 2);
    wait_st(1'b0, 3'd2, 20, ok); all_ok &= ok;
    n_checks++;
    if (!all_ok || valve_open !== 1'b1) begin
      n_fail++; $display("FAIL areset_setup: got state=%0d valve=%0d expected 2/1", state, valve_open);
    end
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || valve_open !== 1'b0 || motor_on !== 1'b0 ||
        bottle_count !== 4'd0 || cork_count !== 5'd20) begin
      n_fail++;
      $display("FAIL areset: got state=%0d valve=%0d motor=%0d bottle=%0d cork=%0d expected 0/0/0/0/20",
               state, valve_open, motor_on, bottle_count, cork_count);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; slow_clk_en = 1'b0;
    start_pb = 1'b0; stop_pb = 1'b0; bottle_sensor = 1'b0; cork_refill = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; bottle2 = 1'b0; refill2 = 1'b0;
    test_reset();
    test_start();
    test_fill_cap();
    test_box();
    test_stop_in_fill();
    test_idle_cases();
    test_empty();
    test_watchdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
